// File: rtl/sha_alu_pipe.sv
// sha_alu_pipe: one-deep pipelined ALU with the SHA-2 sigma, CH and MAJ
// primitives, zero-compare branch decisions and an optional iterative
// shift-add multiplier.
//
// Ports:
//   clk, n_reset_i         rising-edge clock, synchronous active-low reset
//   valid_i / ready_o      request handshake (op_i, a_i, b_i, c_i)
//   valid_o / ready_i      result handshake (result_o, jump_now_o, illegal_o)
//   busy_o                 multiply in progress
//
// Build option: define SHA_ALU_MUL_EN to include MUL (op 24); without it,
// op 24 decodes as illegal and the FSM stays in IDLE.
module sha_alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             jump_now_o,
  output logic             illegal_o,
  output logic             busy_o
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SHA_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam bit W64 = (WIDTH == 64);
  localparam int unsigned BS0_A = W64 ? 28 : 2;
  localparam int unsigned BS0_B = W64 ? 34 : 13;
  localparam int unsigned BS0_C = W64 ? 39 : 22;
  localparam int unsigned BS1_A = W64 ? 14 : 6;
  localparam int unsigned BS1_B = W64 ? 18 : 11;
  localparam int unsigned BS1_C = W64 ? 41 : 25;
  localparam int unsigned SS0_A = W64 ? 1  : 7;
  localparam int unsigned SS0_B = W64 ? 8  : 18;
  localparam int unsigned SS0_S = W64 ? 7  : 3;
  localparam int unsigned SS1_A = W64 ? 19 : 17;
  localparam int unsigned SS1_B = W64 ? 61 : 19;
  localparam int unsigned SS1_S = W64 ? 6  : 10;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
    OP_XOR   = 5'd4,  OP_NOR   = 5'd5,  OP_SLL   = 5'd6,  OP_SRL   = 5'd7,
    OP_SRA   = 5'd8,  OP_ROL   = 5'd9,  OP_ROR   = 5'd10, OP_SLT   = 5'd11,
    OP_SLTU  = 5'd12, OP_CH    = 5'd13, OP_MAJ   = 5'd14, OP_BSIG0 = 5'd15,
    OP_BSIG1 = 5'd16, OP_SSIG0 = 5'd17, OP_SSIG1 = 5'd18, OP_BEQZ  = 5'd19,
    OP_BNEZ  = 5'd20, OP_BGTZ  = 5'd21, OP_BLTZ  = 5'd22, OP_MOV   = 5'd23,
    OP_MUL   = 5'd24
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (WIDTH - n));
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_sum;
  logic [WIDTH-1:0] result_q;
  logic             valid_q, jump_q, illegal_q;

  logic             out_free, accept, is_mul, load_single, mul_wr;
  logic [WIDTH-1:0] mul_res;

  logic [SW-1:0]    shamt;
  logic [SW:0]      inv_sh;
  logic [WIDTH-1:0] rol_v, ror_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_jump, alu_ill;

  assign out_free    = !valid_q || ready_i;
  assign ready_o     = (state_q == IDLE) && out_free;
  assign accept      = valid_i && ready_o;
  assign is_mul      = MUL_EN && (op_i == OP_MUL);
  assign load_single = accept && !is_mul;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  // Final partial product is folded in on the completing edge; in HOLD it is already in acc_q.
  assign mul_res = (state_q == MUL) ? acc_sum : acc_q;

  assign shamt  = b_i[SW-1:0];
  assign inv_sh = (SW+1)'(WIDTH) - (SW+1)'(shamt);
  assign rol_v  = (shamt == '0) ? a_i : ((a_i << shamt) | (a_i >> inv_sh));
  assign ror_v  = (shamt == '0) ? a_i : ((a_i >> shamt) | (a_i << inv_sh));

  always_comb begin
    alu_res  = '0;
    alu_jump = 1'b0;
    alu_ill  = 1'b0;
    case (op_i)
      OP_ADD:   alu_res = a_i + b_i;
      OP_SUB:   alu_res = a_i - b_i;
      OP_AND:   alu_res = a_i & b_i;
      OP_OR:    alu_res = a_i | b_i;
      OP_XOR:   alu_res = a_i ^ b_i;
      OP_NOR:   alu_res = ~(a_i | b_i);
      OP_SLL:   alu_res = a_i << shamt;
      OP_SRL:   alu_res = a_i >> shamt;
      OP_SRA:   alu_res = WIDTH'($signed(a_i) >>> shamt);
      OP_ROL:   alu_res = rol_v;
      OP_ROR:   alu_res = ror_v;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_CH:    alu_res = (a_i & b_i) ^ (~a_i & c_i);
      OP_MAJ:   alu_res = (a_i & b_i) ^ (a_i & c_i) ^ (b_i & c_i);
      OP_BSIG0: alu_res = rotr(a_i, BS0_A) ^ rotr(a_i, BS0_B) ^ rotr(a_i, BS0_C);
      OP_BSIG1: alu_res = rotr(a_i, BS1_A) ^ rotr(a_i, BS1_B) ^ rotr(a_i, BS1_C);
      OP_SSIG0: alu_res = rotr(a_i, SS0_A) ^ rotr(a_i, SS0_B) ^ (a_i >> SS0_S);
      OP_SSIG1: alu_res = rotr(a_i, SS1_A) ^ rotr(a_i, SS1_B) ^ (a_i >> SS1_S);
      OP_BEQZ:  alu_jump = (a_i == '0);
      OP_BNEZ:  alu_jump = (a_i != '0);
      OP_BGTZ:  alu_jump = !a_i[WIDTH-1] && (a_i != '0);
      OP_BLTZ:  alu_jump = a_i[WIDTH-1];
      OP_MOV:   alu_res = b_i;
      OP_MUL:   alu_ill = !MUL_EN;
      default:  alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mul_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          state_d = MUL;
        end
      end
      MUL: begin
        if (cnt_q == CW'(1)) begin
          if (out_free) begin
            mul_wr  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          mul_wr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset_i) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      jump_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (load_single) begin
        result_q  <= alu_res;
        jump_q    <= alu_jump;
        illegal_q <= alu_ill;
        valid_q   <= 1'b1;
      end else if (mul_wr) begin
        result_q  <= mul_res;
        jump_q    <= 1'b0;
        illegal_q <= 1'b0;
        valid_q   <= 1'b1;
      end else if (ready_i) begin
        valid_q   <= 1'b0;
      end

      if (accept && is_mul) begin
        mcand_q  <= a_i;
        mplier_q <= b_i;
        acc_q    <= '0;
        cnt_q    <= CW'(WIDTH);
      end else if (state_q == MUL) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= acc_sum;
        cnt_q    <= cnt_q - CW'(1);
      end
    end
  end

  assign result_o   = result_q;
  assign valid_o    = valid_q;
  assign jump_now_o = jump_q;
  assign illegal_o  = illegal_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_sha_alu_pipe.sv
// Directed bench for sha_alu_pipe at WIDTH=32. Covers the multiply path when
// SHA_ALU_MUL_EN is defined, otherwise checks op 24 decodes as illegal.
module tb_sha_alu_pipe;

  logic        clk;
  logic        n_reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  op_i;
  logic [31:0] a_i, b_i, c_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        jump_now_o;
  logic        illegal_o;
  logic        busy_o;

  int unsigned n_vec;
  int unsigned n_err;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] res;
    logic        jmp;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  sha_alu_pipe #(.WIDTH(32)) dut (
    .clk        (clk),
    .n_reset_i  (n_reset_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .c_i        (c_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .jump_now_o (jump_now_o),
    .illegal_o  (illegal_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] res, input logic jmp,
                         input logic ill);
    vq.push_back(vec_t'{op, a, b, c, res, jmp, ill});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    c_i     = c;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  initial begin
    int unsigned seen_valid;
    n_vec     = 0;
    n_err     = 0;
    n_reset_i = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    op_i      = '0;
    a_i       = '0;
    b_i       = '0;
    c_i       = '0;

    repeat (3) @(posedge clk);
    #1;
    n_reset_i = 1'b1;

    check_eq("rst.valid",   valid_o,    1'b0);
    check_eq("rst.result",  result_o,   32'h0);
    check_eq("rst.jump",    jump_now_o, 1'b0);
    check_eq("rst.illegal", illegal_o,  1'b0);
    check_eq("rst.busy",    busy_o,     1'b0);
    check_eq("rst.ready",   ready_o,    1'b1);

    //       op     a             b             c             result        j     ill
    add_vec(5'd0,  32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h00000001, 1'b0, 1'b0);
    add_vec(5'd1,  32'h00000000, 32'h00000001, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0);
    add_vec(5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, 1'b0, 1'b0);
    add_vec(5'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'h0,        32'hFFFFF0F0, 1'b0, 1'b0);
    add_vec(5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0FF00FF0, 1'b0, 1'b0);
    add_vec(5'd5,  32'h0F0F0F0F, 32'hF0F00000, 32'h0,        32'h0000F0F0, 1'b0, 1'b0);
    add_vec(5'd6,  32'h00000001, 32'h00000023, 32'h0,        32'h00000008, 1'b0, 1'b0);
    add_vec(5'd6,  32'h00000001, 32'h0000001F, 32'h0,        32'h80000000, 1'b0, 1'b0);
    add_vec(5'd7,  32'h80000000, 32'h00000004, 32'h0,        32'h08000000, 1'b0, 1'b0);
    add_vec(5'd8,  32'h80000000, 32'h00000004, 32'h0,        32'hF8000000, 1'b0, 1'b0);
    add_vec(5'd9,  32'h80000001, 32'h00000004, 32'h0,        32'h00000018, 1'b0, 1'b0);
    add_vec(5'd9,  32'h80000001, 32'h00000000, 32'h0,        32'h80000001, 1'b0, 1'b0);
    add_vec(5'd10, 32'h00000001, 32'h00000001, 32'h0,        32'h80000000, 1'b0, 1'b0);
    add_vec(5'd10, 32'h12345678, 32'h00000000, 32'h0,        32'h12345678, 1'b0, 1'b0);
    add_vec(5'd11, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000001, 1'b0, 1'b0);
    add_vec(5'd12, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000000, 1'b0, 1'b0);
    add_vec(5'd13, 32'hFF00FF00, 32'h12345678, 32'hABCDEF01, 32'h12CD5601, 1'b0, 1'b0);
    add_vec(5'd14, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 32'hFFF0F000, 1'b0, 1'b0);
    add_vec(5'd15, 32'h00000001, 32'h0,        32'h0,        32'h40080400, 1'b0, 1'b0);
    add_vec(5'd16, 32'h00000001, 32'h0,        32'h0,        32'h04200080, 1'b0, 1'b0);
    add_vec(5'd17, 32'h00000001, 32'h0,        32'h0,        32'h02004000, 1'b0, 1'b0);
    add_vec(5'd18, 32'h00000001, 32'h0,        32'h0,        32'h0000A000, 1'b0, 1'b0);
    add_vec(5'd18, 32'h00000400, 32'h0,        32'h0,        32'h02800001, 1'b0, 1'b0);
    add_vec(5'd19, 32'h00000000, 32'h00000055, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add_vec(5'd20, 32'h00000000, 32'h00000055, 32'h0,        32'h00000000, 1'b0, 1'b0);
    add_vec(5'd20, 32'h00000010, 32'h00000055, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add_vec(5'd21, 32'h80000000, 32'h00000055, 32'h0,        32'h00000000, 1'b0, 1'b0);
    add_vec(5'd21, 32'h00000005, 32'h00000055, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add_vec(5'd22, 32'h80000000, 32'h00000055, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add_vec(5'd23, 32'h11111111, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    add_vec(5'd27, 32'h11111111, 32'h22222222, 32'h0,        32'h00000000, 1'b0, 1'b1);
    add_vec(5'd0,  32'h00000003, 32'h00000004, 32'h0,        32'h00000007, 1'b0, 1'b0);

    // Back-to-back issue with ready_i held high.
    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d_op%0d", i, vq[i].op);
      check_eq({tag, ".ready"}, ready_o, 1'b1);
      issue(vq[i].op, vq[i].a, vq[i].b, vq[i].c);
      check_eq({tag, ".valid"},   valid_o,    1'b1);
      check_eq({tag, ".result"},  result_o,   vq[i].res);
      check_eq({tag, ".jump"},    jump_now_o, vq[i].jmp);
      check_eq({tag, ".illegal"}, illegal_o,  vq[i].ill);
    end

    // Drain, then stall the consumer with a competing request pending.
    @(posedge clk);
    #1;
    check_eq("drain.valid", valid_o, 1'b0);
    ready_i = 1'b0;
    issue(5'd0, 32'h00000003, 32'h00000004, 32'h0);
    check_eq("stall.accept_valid",  valid_o,  1'b1);
    check_eq("stall.accept_result", result_o, 32'h00000007);
    valid_i = 1'b1;
    op_i    = 5'd0;
    a_i     = 32'h00000100;
    b_i     = 32'h00000001;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("stall%0d.ready", k), ready_o, 1'b0);
      @(posedge clk);
      #1;
      check_eq($sformatf("stall%0d.valid", k),  valid_o,  1'b1);
      check_eq($sformatf("stall%0d.result", k), result_o, 32'h00000007);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release.valid",  valid_o,  1'b0);
    check_eq("release.ready",  ready_o,  1'b1);
    check_eq("release.result", result_o, 32'h00000007);

`ifdef SHA_ALU_MUL_EN
    issue(5'd24, 32'hFFFFFFFF, 32'h00000002, 32'h0);
    for (int k = 0; k < 32; k++) begin
      check_eq($sformatf("mul1.c%0d.busy", k),  busy_o,  1'b1);
      check_eq($sformatf("mul1.c%0d.ready", k), ready_o, 1'b0);
      check_eq($sformatf("mul1.c%0d.valid", k), valid_o, 1'b0);
      @(posedge clk);
      #1;
    end
    check_eq("mul1.valid",   valid_o,   1'b1);
    check_eq("mul1.result",  result_o,  32'hFFFFFFFE);
    check_eq("mul1.busy",    busy_o,    1'b0);
    check_eq("mul1.illegal", illegal_o, 1'b0);
    check_eq("mul1.ready",   ready_o,   1'b1);

    issue(5'd24, 32'h12345678, 32'h00000009, 32'h0);
    repeat (31) @(posedge clk);
    #1;
    check_eq("mul2.early_valid", valid_o, 1'b0);
    @(posedge clk);
    #1;
    check_eq("mul2.valid",  valid_o,  1'b1);
    check_eq("mul2.result", result_o, 32'hA3D70A38);

    // Reset lands mid-multiply: nothing may come out afterwards.
    issue(5'd24, 32'h00000003, 32'h00000005, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("mulrst.busy_before", busy_o, 1'b1);
    n_reset_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mulrst.valid",   valid_o,    1'b0);
    check_eq("mulrst.result",  result_o,   32'h0);
    check_eq("mulrst.jump",    jump_now_o, 1'b0);
    check_eq("mulrst.illegal", illegal_o,  1'b0);
    check_eq("mulrst.busy",    busy_o,     1'b0);
    n_reset_i = 1'b1;
    check_eq("mulrst.ready", ready_o, 1'b1);
    seen_valid = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (valid_o) seen_valid++;
    end
    check_eq("mulrst.no_result", 64'(seen_valid), 64'd0);
`else
    issue(5'd24, 32'hFFFFFFFF, 32'h00000002, 32'h0);
    check_eq("mul_off.valid",   valid_o,   1'b1);
    check_eq("mul_off.result",  result_o,  32'h0);
    check_eq("mul_off.illegal", illegal_o, 1'b1);
    check_eq("mul_off.busy",    busy_o,    1'b0);
    check_eq("mul_off.ready",   ready_o,   1'b1);
    seen_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (busy_o) seen_valid++;
    end
    check_eq("mul_off.never_busy", 64'(seen_valid), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha_alu_pipe.md
SHA_ALU_PIPE -- requirements
Module: sha_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 32 (SHA-256 sigma set) and 64 (SHA-512 sigma set); SW = log2(WIDTH).
REQ-002 SHALL have ports, clock and reset first:
  clk  input  1  sole clock, rising edge.
  n_reset_i  input  1  synchronous, active-low reset.
  valid_i  input  1  request valid.
  ready_o  output  1  block accepts request this cycle.
  op_i  input  5  operation code (REQ-006).
  a_i  input  WIDTH  operand A (rd).
  b_i  input  WIDTH  operand B (rs).
  c_i  input  WIDTH  operand C (CH/MAJ third input).
  valid_o  output  1  result valid.
  ready_i  input  1  consumer takes result.
  result_o  output  WIDTH  registered result.
  jump_now_o  output  1  registered branch decision.
  illegal_o  output  1  registered: op was illegal.
  busy_o  output  1  multi-cycle op in progress.

Function
REQ-003 SHALL accept a request on a rising edge where valid_i && ready_o; op_i/a_i/b_i/c_i sampled only then.
REQ-004 SHALL drive ready_o = (state==IDLE) && (!valid_o || ready_i).
REQ-005 SHALL hold result_o, jump_now_o, illegal_o, valid_o stable while valid_o && !ready_i; valid_o clears on the edge where ready_i is high and no new result is loaded.
REQ-006 SHALL decode op_i: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 ROL, 10 ROR, 11 SLT, 12 SLTU, 13 CH, 14 MAJ, 15 BSIG0, 16 BSIG1, 17 SSIG0, 18 SSIG1, 19 BEQZ, 20 BNEZ, 21 BGTZ, 22 BLTZ, 23 MOV, 24 MUL, 25-31 illegal.
REQ-007 SHALL compute arithmetic modulo 2^WIDTH; shift/rotate amount b_i[SW-1:0]; rotate by 0 returns a_i unchanged; SRA/SLT/BGTZ/BLTZ signed, SLTU unsigned; SLT/SLTU result 1 or 0.
REQ-008 SHALL compute CH=(a&b)^(~a&c), MAJ=(a&b)^(a&c)^(b&c), sigma functions on a_i: WIDTH=32 BSIG0 ROTR2^13^22, BSIG1 ROTR6^11^25, SSIG0 ROTR7^18^SHR3, SSIG1 ROTR17^19^SHR10; WIDTH=64 BSIG0 ROTR28^34^39, BSIG1 ROTR14^18^41, SSIG0 ROTR1^8^SHR7, SSIG1 ROTR19^61^SHR6.
REQ-009 SHALL for branch ops 19-22 set jump_now_o from a_i (==0, !=0, >0, <0) and result_o=0; jump_now_o=0 for all other ops; MOV result = b_i.
REQ-010 SHALL present single-cycle ops (0-23) with valid_o high on the edge after acceptance (latency 1); back-to-back acceptance allowed when ready_i=1.
REQ-011 SHALL implement MUL (low WIDTH bits of a_i*b_i, unsigned) as iterative shift-add, one operand bit per cycle, FSM IDLE->MUL->(HOLD)->IDLE.
REQ-012 SHALL in MUL: load counter WIDTH at acceptance, decrement each cycle, busy_o=1; at count reaching 0, write result and go IDLE if output register free, else go HOLD.
REQ-013 SHALL in HOLD keep busy_o=1, wait for output register free, then load result, valid_o=1, go IDLE; MUL latency = WIDTH cycles to valid_o with ready_i=1.
REQ-014 SHALL for illegal ops produce result_o=0, jump_now_o=0, illegal_o=1, latency 1; illegal_o=0 for legal ops.

Reset
REQ-015 SHALL on n_reset_i low at rising edge: state IDLE, counter 0, valid_o=0, result_o=0, jump_now_o=0, illegal_o=0, busy_o=0; ready_o=1 on first cycle after release.
REQ-016 SHALL abort any in-flight MUL on reset with no result issued.

Configuration
REQ-017 SHALL with SHA_ALU_MUL_EN defined include MUL per REQ-011..013; without it op 24 is illegal (REQ-014), FSM never leaves IDLE, busy_o constant 0.

Verification
REQ-018 WIDTH=32, op 17, a=0x00000001 -> next cycle valid_o=1, result_o=0x02004000.
REQ-019 op 9, a=0x80000001, b=4 -> 0x00000018; same with b=0 -> 0x80000001.
REQ-020 MUL_EN, op 24, a=0xFFFFFFFF, b=0x2, ready_i=1 -> ready_o=0, busy_o=1 for 32 cycles; valid_o at cycle 32, result 0xFFFFFFFE.
REQ-021 op 0 accepted, ready_i=0 for 5 cycles -> result held, ready_o=0; ready_i=1 -> valid_o drops next edge, ready_o=1.
REQ-022 MUL in progress, n_reset_i low at cycle 10 -> all outputs 0, busy_o=0, no valid_o afterward.
REQ-023 op 27 (and op 24 without MUL_EN) -> result_o=0, illegal_o=1, latency 1.
